spi_ram_bridge: RTL and testbench

SPI slave front end that drives the RAM interface: deserialises MOSI frames into 10-bit RAM words with a one-cycle `rx_valid` strobe, and serialises the 8-bit RAM read response back out on MISO. It is the initiator side of the `din`/`rx_valid`/`dout`/`tx_valid` link, and the RAM is the responder. It sits between the top-level SPI pins and the RAM.

---
 rtl/spi_ram_bridge_pkg.sv | 23 ++
 rtl/spi_ram_bridge_if.sv | 26 ++
 rtl/spi_miso_serializer.sv | 54 +++++
 rtl/spi_ram_bridge.sv | 88 ++++++++
 tb/tb_spi_ram_bridge.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_bridge_pkg.sv
// Shared types and constants for the SPI-to-RAM bridge.
// Combinational definitions only, no latency or backpressure.
package shared_pkg;

    localparam int RX_W_DEF = 10;
    localparam int TX_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

endpackage

// File: rtl/spi_ram_bridge_if.sv
// SPI pin and RAM-side link bundle; slave modport is the bridge, master is its environment.
// Wires only, no latency; the RAM side has no backpressure, tx_valid is a plain strobe.
interface spi_ram_bridge_if import shared_pkg::*; #(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) ();

    logic            ss_n;
    logic            mosi;
    logic            miso;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_miso_serializer.sv
// Shifts a captured read byte out MSB first, first bit one cycle after load.
// No backpressure: abort wins over load and forces miso low at once.
module spi_miso_serializer #(
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            abort_i,
    input  logic [TX_W-1:0] data_i,
    output logic            miso_o,
    output logic            done_o
);

    localparam int CW = $clog2(TX_W);
    localparam logic [CW-1:0] LAST = CW'(TX_W - 1);

    logic [TX_W-1:0] sh_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            miso_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else if (load_i) begin
            // MSB goes straight to the pin; the rest wait in the shifter
            miso_q <= data_i[TX_W-1];
            sh_q   <= {data_i[TX_W-2:0], 1'b0};
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == LAST) begin
                miso_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                miso_q <= sh_q[TX_W-1];
                sh_q   <= {sh_q[TX_W-2:0], 1'b0};
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    assign miso_o = miso_q;
    assign done_o = ~busy_q;

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI slave: deserialises 10-bit frames to the RAM (rx_valid 1 cycle after last bit) and returns read bytes on miso.
// No backpressure; ss_n high aborts any frame or byte in flight on the next edge.
module spi_ram_bridge import shared_pkg::*; #(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_ram_bridge_if.slave       bus
);

    localparam int CNT_W = $clog2(RX_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RX_W);

    spi_state_e       state_q;
    logic [RX_W-1:0]  rx_data_q;
    logic             rx_valid_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic             addr_seen_q;
    logic             wait_q;

    logic ser_load;
    logic ser_abort;
    logic ser_done;

    assign ser_abort = (state_q != IDLE) && bus.ss_n;
    assign ser_load  = (state_q == READ_DATA) && wait_q && bus.tx_valid && ser_done && !bus.ss_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_cnt_q    <= '0;
            addr_seen_q <= 1'b0;
            wait_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q != IDLE && bus.ss_n) begin
                state_q  <= IDLE;
                rx_cnt_q <= '0;
                wait_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!bus.ss_n) state_q <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        if (!bus.mosi)       state_q <= WRITE;
                        else if (addr_seen_q) state_q <= READ_DATA;
                        else                  state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (rx_cnt_q != FULL) begin
                            rx_data_q <= {rx_data_q[RX_W-2:0], bus.mosi};
                            rx_cnt_q  <= rx_cnt_q + CNT_W'(1);
                            if (rx_cnt_q == FULL - CNT_W'(1)) begin
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD)  addr_seen_q <= 1'b1;
                                if (state_q == READ_DATA) addr_seen_q <= 1'b0;
                            end
                        end
                        // Arming one cycle after rx_valid keeps a coincident tx_valid out
                        if (state_q == READ_DATA) begin
                            if (rx_valid_q)    wait_q <= 1'b1;
                            else if (ser_load) wait_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    spi_miso_serializer #(.TX_W(TX_W)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .abort_i (ser_abort),
        .data_i  (bus.tx_data),
        .miso_o  (bus.miso),
        .done_o  (ser_done)
    );

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Bench for spi_ram_bridge: table of frames plus hand-written reset sequence,
// with a per-cycle scoreboard for miso bits and rx_valid/rx_data.
module tb_spi_ram_bridge;
    import shared_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_ram_bridge_if #(.RX_W(10), .TX_W(8)) bus ();

    spi_ram_bridge #(.RX_W(10), .TX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [9:0] data;
        int         cyc;
    } rx_exp_t;

    rx_exp_t rx_q[$];
    logic    miso_q[$];

    typedef struct {
        logic       cmd;
        logic [9:0] pay;
        int         nbits;
        int         hold;
        int         txk;
        logic [7:0] txd;
        spi_state_e exp_st;
        logic       exp_as;
        logic       exp_miso;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: one expected miso bit per cycle (0 when nothing queued) and timed rx words
    always @(negedge clk) begin
        logic em;
        if (mon_en && !rst) begin
            em = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
            check("miso", {31'd0, bus.miso}, {31'd0, em});
            while (rx_q.size() > 0 && rx_q[0].cyc < ncyc) begin
                check("rx_valid_missed", 32'd0, 32'd1);
                void'(rx_q.pop_front());
            end
            if (rx_q.size() > 0 && rx_q[0].cyc == ncyc) begin
                check("rx_valid_pulse", {31'd0, bus.rx_valid}, 32'd1);
                check("rx_data", {22'd0, bus.rx_data}, {22'd0, rx_q[0].data});
                void'(rx_q.pop_front());
            end else begin
                check("rx_valid_quiet", {31'd0, bus.rx_valid}, 32'd0);
            end
        end
        ncyc++;
    end

    task automatic start_frame(input logic cmd, input logic [9:0] pay, input int nbits,
                               input spi_state_e exp_st);
        bus.ss_n = 1'b0;
        bus.mosi = 1'($urandom);
        step();
        check("state_e0", {29'd0, dut.state_q}, {29'd0, CHK_CMD});
        bus.mosi = cmd;
        step();
        check("state_cmd", {29'd0, dut.state_q}, {29'd0, exp_st});
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = pay[9-i];
            if (i == 9) rx_q.push_back('{pay, ncyc + 1});
            step();
        end
    endtask

    task automatic hold(input int n, input int txk, input logic [7:0] txd, input logic accept);
        for (int k = 0; k < n; k++) begin
            bus.mosi     = 1'($urandom);
            bus.tx_valid = (k == txk);
            bus.tx_data  = txd;
            if (k == txk && accept) begin
                miso_q.push_back(1'b0);
                for (int b = 7; b >= 0; b--) miso_q.push_back(txd[b]);
            end
            step();
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic end_frame();
        // The bit on the pin before the aborting edge still shows; everything after is 0
        while (miso_q.size() > 1) void'(miso_q.pop_back());
        bus.ss_n = 1'b1;
        step();
        check("state_idle", {29'd0, dut.state_q}, {29'd0, IDLE});
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 10'h0A5, 10, 2,  -1, 8'h00, WRITE,     1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'h1C3, 10, 3,   1, 8'h5A, WRITE,     1'b0, 1'b0};
        vecs[2]  = '{1'b1, 10'h207, 10, 2,  -1, 8'h00, READ_ADD,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 10'h300, 10, 12,  2, 8'hB6, READ_DATA, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 10'h2F0, 6,  0,  -1, 8'h00, WRITE,     1'b0, 1'b0};
        vecs[5]  = '{1'b1, 10'h2AA, 10, 2,  -1, 8'h00, READ_ADD,  1'b1, 1'b0};
        vecs[6]  = '{1'b1, 10'h3AB, 4,  0,  -1, 8'h00, READ_DATA, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 10'h3FF, 10, 12,  0, 8'hC3, READ_DATA, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 10'h211, 10, 2,  -1, 8'h00, READ_ADD,  1'b1, 1'b0};
        vecs[9]  = '{1'b1, 10'h300, 10, 5,   1, 8'hA5, READ_DATA, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 10'h055, 10, 0,  -1, 8'h00, WRITE,     1'b0, 1'b0};

        bus.ss_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        rst          = 1'b1;
        step();
        step();
        check("reset_rx_valid",  {31'd0, bus.rx_valid}, 32'd0);
        check("reset_rx_data",   {22'd0, bus.rx_data}, 32'd0);
        check("reset_miso",      {31'd0, bus.miso}, 32'd0);
        check("reset_state",     {29'd0, dut.state_q}, {29'd0, IDLE});
        check("reset_addr_seen", {31'd0, dut.addr_seen_q}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        foreach (vecs[v]) begin
            start_frame(vecs[v].cmd, vecs[v].pay, vecs[v].nbits, vecs[v].exp_st);
            hold(vecs[v].hold, vecs[v].txk, vecs[v].txd, vecs[v].exp_miso);
            if (vecs[v].nbits == 10)
                check("rx_data_hold", {22'd0, bus.rx_data}, {22'd0, vecs[v].pay});
            end_frame();
            check("addr_seen", {31'd0, dut.addr_seen_q}, {31'd0, vecs[v].exp_as});
        end

        // Asynchronous reset in the middle of shifting out 0xFF
        start_frame(1'b1, 10'h201, 10, READ_ADD);
        hold(1, -1, 8'h00, 1'b0);
        end_frame();
        check("addr_seen_pre_rst", {31'd0, dut.addr_seen_q}, 32'd1);
        start_frame(1'b1, 10'h3C0, 10, READ_DATA);
        hold(4, 1, 8'hFF, 1'b1);
        check("miso_before_rst", {31'd0, bus.miso}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_miso",     {31'd0, bus.miso}, 32'd0);
        check("rst_async_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_async_rx_data",  {22'd0, bus.rx_data}, 32'd0);
        check("rst_async_state",    {29'd0, dut.state_q}, {29'd0, IDLE});
        miso_q.delete();
        rx_q.delete();
        bus.ss_n     = 1'b1;
        bus.tx_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_state",     {29'd0, dut.state_q}, {29'd0, IDLE});
        check("post_rst_addr_seen", {31'd0, dut.addr_seen_q}, 32'd0);

        start_frame(1'b0, 10'h155, 10, WRITE);
        hold(2, -1, 8'h00, 1'b0);
        check("rx_data_after_rst", {22'd0, bus.rx_data}, 32'h155);
        end_frame();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
